mux_4channel_arbiter: RTL and testbench

MUX_4CHANNEL_ARBITER -- requirements
Module: mux_4channel_arbiter

---
 rtl/mux_4channel_pkg.sv | 16 +
 rtl/mux_4channel_rr_pick.sv | 26 ++
 rtl/mux_4channel_arbiter.sv | 97 +++++++++
 tb/tb_mux_4channel_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_4channel_pkg.sv
// rtl/mux_4channel_pkg.sv - shared types and constants for the 4-channel arbiter
package mux_4channel_pkg;

  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [CHANNELS-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    return CHANNELS'(1) << sel;
  endfunction

endpackage

// File: rtl/mux_4channel_rr_pick.sv
// rtl/mux_4channel_rr_pick.sv - rotating-priority pick of the first requester at or after PTR
module mux_4channel_rr_pick
  import mux_4channel_pkg::*;
(
  input  logic [CHANNELS-1:0] REQUEST,
  input  logic [SEL_W-1:0]    PTR,
  output logic [SEL_W-1:0]    WINNER,
  output logic                ANY_REQ
);

  logic [SEL_W-1:0] idx;

  // Walk from the farthest offset back to PTR so the nearest requester is written last.
  always_comb begin
    idx     = '0;
    WINNER  = '0;
    ANY_REQ = |REQUEST;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = PTR + SEL_W'(i);
      if (REQUEST[idx]) begin
        WINNER = idx;
      end
    end
  end

endmodule

// File: rtl/mux_4channel_arbiter.sv
// rtl/mux_4channel_arbiter.sv - round-robin 4:1 data mux with bounded hold and break-before-make
module mux_4channel_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] REQUEST,
  input  logic       INPUT_1,
  input  logic       INPUT_2,
  input  logic       INPUT_3,
  input  logic       INPUT_4,
  output logic [3:0] GRANT,
  output logic       SELECTOR_1,
  output logic       SELECTOR_2,
  output logic       OUTPUT_1,
  output logic       VALID,
  output logic       BUSY
);

  import mux_4channel_pkg::*;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] owner_q;
  logic [SEL_W-1:0] ptr_q;
  logic [7:0]       hold_q;
  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic [3:0]       channel_data;

  assign channel_data             = {INPUT_4, INPUT_3, INPUT_2, INPUT_1};
  assign {SELECTOR_1, SELECTOR_2} = owner_q;

  mux_4channel_rr_pick u_pick (
    .REQUEST (REQUEST),
    .PTR     (ptr_q),
    .WINNER  (winner),
    .ANY_REQ (any_req)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = mux_4channel_pkg::BUSY;
        end
      end
      mux_4channel_pkg::BUSY: begin
        if (!REQUEST[owner_q] || hold_q == 8'(MAX_HOLD)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
      GRANT    <= '0;
      OUTPUT_1 <= 1'b0;
      VALID    <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state_q <= state_d;
      VALID   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            GRANT   <= sel_to_onehot(winner);
            BUSY    <= 1'b1;
            hold_q  <= 8'd1;
          end
        end
        mux_4channel_pkg::BUSY: begin
          OUTPUT_1 <= channel_data[owner_q];
          VALID    <= 1'b1;
          // Leaving always passes through IDLE, which forces the break-before-make gap.
          if (state_d == IDLE) begin
            GRANT  <= '0;
            BUSY   <= 1'b0;
            ptr_q  <= owner_q + 2'd1;
            hold_q <= '0;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4channel_arbiter.sv
// tb/tb_mux_4channel_arbiter.sv - self-checking bench for mux_4channel_arbiter
module tb_mux_4channel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] din = '0;

  logic [3:0] grant [4];
  logic       sel1  [4];
  logic       sel2  [4];
  logic       out1  [4];
  logic       valid [4];
  logic       busy  [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: MAX_HOLD is 8, 1, 2, 3 for instances 0..3
  bit m_busy  [4];
  int m_owner [4];
  int m_cnt   [4];
  int m_ptr   [4];
  bit m_out   [4];
  bit m_valid [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mux_4channel_arbiter #(.MAX_HOLD(g == 0 ? 8 : g)) dut (
      .CLK        (clk),
      .RESET      (rst),
      .REQUEST    (req),
      .INPUT_1    (din[0]),
      .INPUT_2    (din[1]),
      .INPUT_3    (din[2]),
      .INPUT_4    (din[3]),
      .GRANT      (grant[g]),
      .SELECTOR_1 (sel1[g]),
      .SELECTOR_2 (sel2[g]),
      .OUTPUT_1   (out1[g]),
      .VALID      (valid[g]),
      .BUSY       (busy[g])
    );
  end

  function automatic int max_hold(input int d);
    return (d == 0) ? 8 : d;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        m_busy[d]  = 0;
        m_owner[d] = 0;
        m_cnt[d]   = 0;
        m_ptr[d]   = 0;
        m_out[d]   = 0;
        m_valid[d] = 0;
      end else if (!m_busy[d]) begin
        m_valid[d] = 0;
        if (req != 0) begin
          bit found = 0;
          for (int k = 0; k < 4; k++) begin
            int c = (m_ptr[d] + k) % 4;
            if (!found && req[c]) begin
              m_owner[d] = c;
              found = 1;
            end
          end
          m_busy[d] = 1;
          m_cnt[d]  = 1;
        end
      end else begin
        m_out[d]   = din[m_owner[d]];
        m_valid[d] = 1;
        if (!req[m_owner[d]] || m_cnt[d] == max_hold(d)) begin
          m_busy[d] = 0;
          m_ptr[d]  = (m_owner[d] + 1) % 4;
          m_cnt[d]  = 0;
        end else begin
          m_cnt[d]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("grant[%0d]", d), grant[d], m_busy[d] ? (8'd1 << m_owner[d]) : 8'd0);
      check($sformatf("sel[%0d]", d), {sel1[d], sel2[d]}, m_owner[d]);
      check($sformatf("busy[%0d]", d), busy[d], m_busy[d]);
      check($sformatf("valid[%0d]", d), valid[d], m_valid[d]);
      check($sformatf("out[%0d]", d), out1[d], m_out[d]);
      check($sformatf("onehot[%0d]", d), $countones(grant[d]) <= 1, 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("reset_grant", grant[0], 0);
    check("reset_busy", busy[0], 0);
    rst = 1'b0;

    // Sole requester channel 1 for three cycles, then pointer moves to channel 2
    req = 4'b0001;
    tick();
    check("r29_grant", grant[0], 4'b0001);
    check("r29_sel", {sel1[0], sel2[0]}, 0);
    tick();
    tick();
    check("r29_busy3", busy[0], 1);
    req = 4'b0000;
    tick();
    check("r29_idle", busy[0], 0);
    req = 4'b1111;
    tick();
    check("r29_ptr", grant[0], 4'b0010);

    // Reset in the middle of a grant
    tick();
    rst = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) begin
      check("r33_grant", grant[d], 0);
      check("r33_out", {sel1[d], sel2[d], out1[d], valid[d], busy[d]}, 0);
    end
    rst = 1'b0;
    tick();
    check("r33_first", grant[0], 4'b0001);

    // All requesting: MAX_HOLD 2 gives 2-cycle grants, MAX_HOLD 1 gives 1-cycle grants
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("r30_mh2", grant[2], (i % 3 == 2) ? 8'd0 : (8'd1 << ((i / 3) % 4)));
      check("r21_mh1", grant[1], (i % 2 == 1) ? 8'd0 : (8'd1 << ((i / 2) % 4)));
    end

    // Channel 4 owner drops; next grant wraps to channel 1
    do_reset();
    req = 4'b1000;
    tick();
    check("r31_grant4", grant[0], 4'b1000);
    check("r31_sel11", {sel1[0], sel2[0]}, 3);
    req = 4'b0011;
    tick();
    check("r31_gap", grant[0], 0);
    tick();
    check("r31_grant1", grant[0], 4'b0001);
    check("r31_sel00", {sel1[0], sel2[0]}, 0);

    // Data path from channel 3
    do_reset();
    din = 4'b1011;
    req = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      din = (i == 1) ? 4'b1111 : 4'b1011;
      tick();
      check("r32_out", out1[0], (i == 1) ? 1 : 0);
      check("r32_valid", valid[0], 1);
    end

    // Sole requester channel 2 with MAX_HOLD 3: re-grant after one idle cycle
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("r34_grant", grant[3], (i % 4 == 3) ? 8'd0 : 8'd2);
    end

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      din = 4'($urandom_range(0, 15));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
